// File: rtl/niosii_soc_nios2_oci_dct_packer_pkg.sv
// Shared constants and types for the OCI data-trace packer path.
package niosii_soc_oci_trace_pkg;

    localparam int ATOM_W = 2;
    localparam int SLOTS  = 15;
    localparam int CNT_W  = 4;
    localparam int BUF_W  = ATOM_W * SLOTS;

    typedef logic [ATOM_W-1:0] atom_t;
    typedef logic [BUF_W-1:0]  dct_buf_t;
    typedef logic [CNT_W-1:0]  dct_cnt_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ENDED = 2'd2
    } pack_state_t;

    localparam dct_cnt_t FULL_CNT = dct_cnt_t'(SLOTS);

    // Atom positioned at its slot; slot 0 is the oldest atom at bits [1:0].
    function automatic dct_buf_t place_atom(atom_t a, dct_cnt_t slot);
        dct_buf_t b;
        b = dct_buf_t'(a);
        return b << (ATOM_W * int'(slot));
    endfunction

endpackage

// File: rtl/niosii_soc_nios2_oci_dct_packer_if.sv
// Atom input and packed-buffer output handshakes of the DCT packer.
interface niosii_soc_nios2_oci_dct_packer_if;
    import niosii_soc_oci_trace_pkg::*;

    atom_t    atom_in;
    logic     atom_valid;
    logic     atom_ready;
    dct_buf_t dct_buffer;
    dct_cnt_t dct_count;
    logic     dct_valid;
    logic     dct_ready;

    modport slave (
        input  atom_in, atom_valid, dct_ready,
        output atom_ready, dct_buffer, dct_count, dct_valid
    );

    modport master (
        output atom_in, atom_valid, dct_ready,
        input  atom_ready, dct_buffer, dct_count, dct_valid
    );

endinterface

// File: rtl/niosii_soc_nios2_oci_dct_packer_outreg.sv
// One-entry valid/ready output register; a load on an accept cycle replaces
// the departing entry without a bubble.
module niosii_soc_oci_dct_outreg
    import niosii_soc_oci_trace_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     load,
    input  dct_buf_t load_buf,
    input  dct_cnt_t load_cnt,
    input  logic     ready,
    output logic     free,
    output dct_buf_t data,
    output dct_cnt_t cnt,
    output logic     valid
);

    assign free = !valid || ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_buf;
            cnt   <= load_cnt;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/niosii_soc_nios2_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-slot buffers and sequences end-of-test drain.
// Optional stall_count output under NIOSII_SOC_DCT_PACKER_STALL_CNT_EN.
module niosii_soc_nios2_oci_dct_packer
    import niosii_soc_oci_trace_pkg::*;
(
    input  logic clk,
    input  logic reset,
    niosii_soc_nios2_oci_dct_packer_if.slave bus,
    input  logic flush_req,
    input  logic end_req,
    output logic test_ending,
    output logic test_has_ended
`ifdef NIOSII_SOC_DCT_PACKER_STALL_CNT_EN
    ,
    output logic [15:0] stall_count
`endif
);

    pack_state_t state, state_nxt;
    dct_buf_t    acc, acc_nxt, load_buf;
    dct_cnt_t    acc_cnt, cnt_nxt, load_cnt;
    logic        flush_pending, flush_nxt;
    logic        out_free, accept, full, close, do_close;

    assign full           = (acc_cnt == FULL_CNT);
    assign bus.atom_ready = (state == RUN) && !(full && !out_free);
    assign accept         = bus.atom_valid && bus.atom_ready;
    assign close          = full || ((acc_cnt != '0) && (flush_pending || state == DRAIN));
    assign do_close       = close && out_free;

    // A full close starts a new buffer with the incoming atom; a flush close
    // folds the incoming atom into the buffer being emitted.
    always_comb begin
        acc_nxt  = acc;
        cnt_nxt  = acc_cnt;
        load_buf = acc;
        load_cnt = acc_cnt;
        if (do_close) begin
            if (full) begin
                acc_nxt = accept ? place_atom(bus.atom_in, '0) : '0;
                cnt_nxt = accept ? dct_cnt_t'(1) : '0;
            end else begin
                acc_nxt = '0;
                cnt_nxt = '0;
                if (accept) begin
                    load_buf = acc | place_atom(bus.atom_in, acc_cnt);
                    load_cnt = acc_cnt + 1'b1;
                end
            end
        end else if (accept) begin
            acc_nxt = acc | place_atom(bus.atom_in, acc_cnt);
            cnt_nxt = acc_cnt + 1'b1;
        end
    end

    always_comb begin
        flush_nxt = flush_pending;
        if (do_close) begin
            flush_nxt = 1'b0;
        end else if (flush_req && state != ENDED && (acc_cnt != '0 || accept)) begin
            flush_nxt = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (end_req) state_nxt = DRAIN;
            DRAIN:   if (acc_cnt == '0 && (!bus.dct_valid || bus.dct_ready)) state_nxt = ENDED;
            ENDED:   state_nxt = ENDED;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            acc           <= '0;
            acc_cnt       <= '0;
            flush_pending <= 1'b0;
        end else begin
            state         <= state_nxt;
            acc           <= acc_nxt;
            acc_cnt       <= cnt_nxt;
            flush_pending <= flush_nxt;
        end
    end

    assign test_ending    = (state != RUN);
    assign test_has_ended = (state == ENDED);

    niosii_soc_oci_dct_outreg u_outreg (
        .clk      (clk),
        .reset    (reset),
        .load     (do_close),
        .load_buf (load_buf),
        .load_cnt (load_cnt),
        .ready    (bus.dct_ready),
        .free     (out_free),
        .data     (bus.dct_buffer),
        .cnt      (bus.dct_count),
        .valid    (bus.dct_valid)
    );

`ifdef NIOSII_SOC_DCT_PACKER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (bus.atom_valid && !bus.atom_ready && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule
